// File: rtl/mem_access_unit.sv
// Load/store stage: accepts one op, issues at most one data-bus request, and
// returns a writeback bundle. Misaligned accesses never reach the bus.
module mem_access_unit #(
    parameter int XLEN = 64,
    parameter int ALEN = 64,
    parameter int DSTW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_memread,
    input  logic              in_memwrite,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ALEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [XLEN-1:0]   in_result,
    input  logic [ALEN-1:0]   in_pc,
    input  logic [DSTW-1:0]   in_dst,
    input  logic              in_regwrite,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_regdata,
    output logic [ALEN-1:0]   out_pc,
    output logic [DSTW-1:0]   out_dst,
    output logic              out_regwrite,
    output logic              out_misalign,
    output logic              dreq_valid,
    output logic [ALEN-1:0]   dreq_addr,
    output logic [1:0]        dreq_size,
    output logic [XLEN/8-1:0] dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_ok,
    input  logic [XLEN-1:0]   dresp_data
);

    localparam int NBYTES = XLEN / 8;
    localparam int OFFW   = $clog2(NBYTES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic              isLoadQ, isStoreQ, unsignedQ, regwriteQ, misalignQ;
    logic [1:0]        sizeQ;
    logic [ALEN-1:0]   addrQ, pcQ;
    logic [XLEN-1:0]   wdataQ, resultQ, respQ;
    logic [DSTW-1:0]   dstQ;

    logic              inMem, inAligned;
    logic [OFFW-1:0]   laneOff;
    logic [XLEN-1:0]   shifted, loadExt, storeData;
    logic [NBYTES-1:0] sizeMask;
    logic              signBit;

    assign inMem = in_memread | in_memwrite;

    // A doubleword access is never aligned on a 32-bit datapath.
    always_comb begin
        inAligned = 1'b0;
        case (in_size)
            2'd0:    inAligned = 1'b1;
            2'd1:    inAligned = ~in_addr[0];
            2'd2:    inAligned = (in_addr[1:0] == 2'b00);
            default: inAligned = (XLEN == 64) && (in_addr[2:0] == 3'b000);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            isLoadQ   <= 1'b0;
            isStoreQ  <= 1'b0;
            unsignedQ <= 1'b0;
            regwriteQ <= 1'b0;
            misalignQ <= 1'b0;
            sizeQ     <= '0;
            addrQ     <= '0;
            pcQ       <= '0;
            wdataQ    <= '0;
            resultQ   <= '0;
            respQ     <= '0;
            dstQ      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        isStoreQ  <= in_memwrite;
                        isLoadQ   <= in_memread & ~in_memwrite;
                        unsignedQ <= in_unsigned;
                        regwriteQ <= in_regwrite;
                        misalignQ <= inMem & ~inAligned;
                        sizeQ     <= in_size;
                        addrQ     <= in_addr;
                        pcQ       <= in_pc;
                        wdataQ    <= in_wdata;
                        resultQ   <= in_result;
                        dstQ      <= in_dst;
                        state     <= (inMem && inAligned) ? BUS : DONE;
                    end
                end
                BUS: begin
                    if (dresp_ok) begin
                        respQ <= dresp_data;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign laneOff = addrQ[OFFW-1:0];
    assign shifted = respQ >> {laneOff, 3'b000};

    always_comb begin
        case (sizeQ)
            2'd0:    storeData = {NBYTES{wdataQ[7:0]}};
            2'd1:    storeData = {(NBYTES/2){wdataQ[15:0]}};
            2'd2:    storeData = {(NBYTES/4){wdataQ[31:0]}};
            default: storeData = wdataQ;
        endcase
    end

    always_comb begin
        sizeMask = '0;
        for (int i = 0; i < NBYTES; i++) sizeMask[i] = (i < (1 << sizeQ));
    end

    always_comb begin
        case (sizeQ)
            2'd0:    signBit = shifted[7];
            2'd1:    signBit = shifted[15];
            2'd2:    signBit = shifted[31];
            default: signBit = shifted[XLEN-1];
        endcase
    end

    // Bits above the access width are filled with the sign bit unless unsigned.
    always_comb begin
        loadExt = '0;
        for (int i = 0; i < XLEN; i++)
            loadExt[i] = (i < (8 << sizeQ)) ? shifted[i] : (~unsignedQ & signBit);
    end

    assign in_ready     = (state == IDLE);
    assign dreq_valid   = (state == BUS);
    assign out_valid    = (state == DONE);
    assign dreq_addr    = addrQ & ~ALEN'(NBYTES - 1);
    assign dreq_size    = sizeQ;
    assign dreq_data    = storeData;
    assign dreq_strobe  = isStoreQ ? (sizeMask << laneOff) : '0;
    assign out_regdata  = misalignQ ? '0 : (isLoadQ ? loadExt : resultQ);
    assign out_regwrite = regwriteQ & ~misalignQ;
    assign out_misalign = misalignQ;
    assign out_pc       = pcQ;
    assign out_dst      = dstQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit (XLEN=64) with a writeback scoreboard
// plus hand-written sequences for output stall and reset during a bus request.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_memread = 1'b0;
    logic        in_memwrite = 1'b0;
    logic [1:0]  in_size = '0;
    logic        in_unsigned = 1'b0;
    logic [63:0] in_addr = '0;
    logic [63:0] in_wdata = '0;
    logic [63:0] in_result = '0;
    logic [63:0] in_pc = '0;
    logic [4:0]  in_dst = '0;
    logic        in_regwrite = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_regdata;
    logic [63:0] out_pc;
    logic [4:0]  out_dst;
    logic        out_regwrite;
    logic        out_misalign;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_ok = 1'b0;
    logic [63:0] dresp_data = '0;

    mem_access_unit #(.XLEN(64), .ALEN(64), .DSTW(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_memread(in_memread), .in_memwrite(in_memwrite),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result),
        .in_pc(in_pc), .in_dst(in_dst), .in_regwrite(in_regwrite),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regdata(out_regdata), .out_pc(out_pc), .out_dst(out_dst),
        .out_regwrite(out_regwrite), .out_misalign(out_misalign),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_ok(dresp_ok), .dresp_data(dresp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          memRead;
        bit          memWrite;
        logic [1:0]  size;
        bit          isUnsigned;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] result;
        bit          regWrite;
        int          waitCycles;
        logic [63:0] respData;
        bit          expBus;
        logic [63:0] expDreqAddr;
        logic [7:0]  expStrobe;
        logic [63:0] expDreqData;
        logic [63:0] expRegData;
        bit          expRegWrite;
        bit          expMisalign;
    } vector_t;

    typedef struct {
        logic [63:0] regData;
        bit          regWrite;
        bit          misalign;
        logic [63:0] pc;
        logic [4:0]  dst;
    } sbEntry_t;

    vector_t  vecs[15];
    sbEntry_t sbQ[$];
    int       testsRun = 0;
    int       testsFailed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every sampling point also confirms the two valids are never high together.
    task automatic tick();
        @(negedge clk);
        check("valid_exclusive", 64'(out_valid & dreq_valid), 64'd0);
    endtask

    task automatic driveInputs(input vector_t v, input int idx);
        in_memread  = v.memRead;
        in_memwrite = v.memWrite;
        in_size     = v.size;
        in_unsigned = v.isUnsigned;
        in_addr     = v.addr;
        in_wdata    = v.wdata;
        in_result   = v.result;
        in_regwrite = v.regWrite;
        in_pc       = 64'h100 + 64'(idx * 4);
        in_dst      = 5'(idx + 5);
        in_valid    = 1'b1;
    endtask

    task automatic checkDreq(input vector_t v);
        check("dreq_valid", 64'(dreq_valid), 64'd1);
        check("dreq_addr", dreq_addr, v.expDreqAddr);
        check("dreq_size", 64'(dreq_size), 64'(v.size));
        check("dreq_strobe", 64'(dreq_strobe), 64'(v.expStrobe));
        if (v.memWrite) check("dreq_data", dreq_data, v.expDreqData);
    endtask

    task automatic applyStimulus(input vector_t v, input int idx);
        sbEntry_t e;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        driveInputs(v, idx);
        e.regData  = v.expRegData;
        e.regWrite = v.expRegWrite;
        e.misalign = v.expMisalign;
        e.pc       = 64'h100 + 64'(idx * 4);
        e.dst      = 5'(idx + 5);
        sbQ.push_back(e);
        tick();
        in_valid = 1'b0;
        if (v.expBus) begin
            check("bus_no_out_valid", 64'(out_valid), 64'd0);
            for (int w = 0; w < v.waitCycles; w++) begin
                checkDreq(v);
                tick();
            end
            checkDreq(v);
            dresp_data = v.respData;
            dresp_ok   = 1'b1;
            tick();
            dresp_ok   = 1'b0;
            dresp_data = '0;
        end else begin
            check("no_dreq_valid", 64'(dreq_valid), 64'd0);
        end
        check("out_valid_latency", 64'(out_valid), 64'd1);
    endtask

    task automatic checkOutput();
        sbEntry_t e;
        check("out_valid_present", 64'(out_valid), 64'd1);
        if (sbQ.size() == 0) begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            e = sbQ.pop_front();
            check("out_regdata", out_regdata, e.regData);
            check("out_regwrite", 64'(out_regwrite), 64'(e.regWrite));
            check("out_misalign", 64'(out_misalign), 64'(e.misalign));
            check("out_pc", out_pc, e.pc);
            check("out_dst", 64'(out_dst), 64'(e.dst));
        end
        out_ready = 1'b1;
        tick();
        check("in_ready_after", 64'(in_ready), 64'd1);
        check("out_valid_cleared", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //        rd wr sz un addr         wdata                  result      rw wt resp                    bus dAddr        strb   dData                  regData                rw mis
        vecs[0]  = '{0, 0, 2'd0, 0, 64'h0,    64'h0,                 64'h1234, 1, 0, 64'h0,                  0, 64'h0,    8'h00, 64'h0,                 64'h1234,              1, 0};
        vecs[1]  = '{1, 0, 2'd1, 0, 64'h1006, 64'h0,                 64'h77,   1, 3, 64'h8001_0000_0000_0000, 1, 64'h1000, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_8001, 1, 0};
        vecs[2]  = '{0, 1, 2'd0, 0, 64'h2003, 64'hAB,                64'h55,   1, 5, 64'h0,                  1, 64'h2000, 8'h08, 64'hABAB_ABAB_ABAB_ABAB, 64'h55,              1, 0};
        vecs[3]  = '{1, 0, 2'd2, 0, 64'h3002, 64'h0,                 64'h99,   1, 0, 64'h0,                  0, 64'h0,    8'h00, 64'h0,                 64'h0,                 0, 1};
        vecs[4]  = '{1, 0, 2'd0, 1, 64'h4005, 64'h0,                 64'h0,    1, 1, 64'h0000_9A00_0000_0000, 1, 64'h4000, 8'h00, 64'h0,                 64'h9A,                1, 0};
        vecs[5]  = '{1, 0, 2'd0, 0, 64'h4005, 64'h0,                 64'h0,    1, 0, 64'h0000_9A00_0000_0000, 1, 64'h4000, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF9A, 1, 0};
        vecs[6]  = '{1, 0, 2'd2, 0, 64'h5004, 64'h0,                 64'h0,    1, 2, 64'h8765_4321_0000_0000, 1, 64'h5000, 8'h00, 64'h0,                 64'hFFFF_FFFF_8765_4321, 1, 0};
        vecs[7]  = '{1, 0, 2'd3, 0, 64'h6008, 64'h0,                 64'h0,    1, 0, 64'h0123_4567_89AB_CDEF, 1, 64'h6008, 8'h00, 64'h0,                 64'h0123_4567_89AB_CDEF, 1, 0};
        vecs[8]  = '{0, 1, 2'd1, 0, 64'h700A, 64'h1234_BEEF,         64'h11,   0, 1, 64'h0,                  1, 64'h7008, 8'h0C, 64'hBEEF_BEEF_BEEF_BEEF, 64'h11,              0, 0};
        vecs[9]  = '{0, 1, 2'd2, 0, 64'h8004, 64'h1122_3344_5566_7788, 64'h22, 0, 0, 64'h0,                  1, 64'h8000, 8'hF0, 64'h5566_7788_5566_7788, 64'h22,              0, 0};
        vecs[10] = '{0, 1, 2'd3, 0, 64'h9000, 64'hCAFE_F00D_DEAD_BEEF, 64'h33, 1, 2, 64'h0,                  1, 64'h9000, 8'hFF, 64'hCAFE_F00D_DEAD_BEEF, 64'h33,              1, 0};
        vecs[11] = '{1, 1, 2'd0, 0, 64'hA001, 64'h7E,                64'h44,   1, 0, 64'h0,                  1, 64'hA000, 8'h02, 64'h7E7E_7E7E_7E7E_7E7E, 64'h44,              1, 0};
        vecs[12] = '{0, 1, 2'd1, 0, 64'hB001, 64'h5,                 64'h66,   1, 0, 64'h0,                  0, 64'h0,    8'h00, 64'h0,                 64'h0,                 0, 1};
        vecs[13] = '{1, 0, 2'd3, 0, 64'hC004, 64'h0,                 64'h0,    1, 0, 64'h0,                  0, 64'h0,    8'h00, 64'h0,                 64'h0,                 0, 1};
        vecs[14] = '{0, 0, 2'd3, 0, 64'h3,    64'h0,                 64'hDEAD, 0, 0, 64'h0,                  0, 64'h0,    8'h00, 64'h0,                 64'hDEAD,              0, 0};

        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_dreq_valid", 64'(dreq_valid), 64'd0);
        check("reset_out_regdata", out_regdata, 64'd0);
        check("reset_dreq_addr", dreq_addr, 64'd0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i], i);
            checkOutput();
        end

        // Downstream stall: bundle must hold and a stray bus response is ignored.
        out_ready = 1'b0;
        applyStimulus(vecs[14], 14);
        for (int s = 0; s < 4; s++) begin
            dresp_ok   = (s == 1);
            dresp_data = 64'hFFFF_0000_FFFF_0000;
            tick();
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_regdata", out_regdata, 64'hDEAD);
            check("stall_no_dreq", 64'(dreq_valid), 64'd0);
        end
        dresp_ok   = 1'b0;
        dresp_data = '0;
        checkOutput();

        // Reset arriving mid-request abandons it without waiting for a clock edge.
        driveInputs(vecs[4], 4);
        tick();
        in_valid = 1'b0;
        check("pre_reset_dreq_valid", 64'(dreq_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_dreq_valid", 64'(dreq_valid), 64'd0);
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        check("async_reset_dreq_addr", dreq_addr, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        check("post_reset_out_regdata", out_regdata, 64'd0);
        applyStimulus(vecs[1], 1);
        checkOutput();

        check("scoreboard_drained", 64'(sbQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter XLEN, default 64: register and data width in bits; legal values 32 or 64.
REQ-002 Parameter ALEN, default 64: address width in bits.
REQ-003 Parameter DSTW, default 5: destination register index width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1 / in_ready  output  1  upstream handshake; a transfer occurs when both are high on a rising edge.
REQ-007 in_memread, in_memwrite  input  1 each  load/store select; both low means pass-through; both high is illegal and is treated as a store.
REQ-008 in_size  input  2  access size 0=B, 1=H, 2=W, 3=D (D is legal only when XLEN=64).
REQ-009 in_unsigned  input  1  zero-extend a load when high, sign-extend when low.
REQ-010 in_addr  input  ALEN / in_wdata  input  XLEN / in_result  input  XLEN  effective address, store data, and ALU result.
REQ-011 in_pc  input  ALEN / in_dst  input  DSTW / in_regwrite  input  1  sideband, carried unchanged to the output.
REQ-012 out_valid  output  1 / out_ready  input  1  downstream handshake.
REQ-013 out_regdata  output  XLEN / out_pc  output  ALEN / out_dst  output  DSTW / out_regwrite  output  1 / out_misalign  output  1  writeback bundle.
REQ-014 dreq_valid  output  1 / dreq_addr  output  ALEN / dreq_size  output  2 / dreq_strobe  output  XLEN/8 / dreq_data  output  XLEN  data-bus request; dreq_strobe is all-zero for a load.
REQ-015 dresp_ok  input  1 / dresp_data  input  XLEN  data-bus response.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUS, DONE; in_ready=1 only in IDLE.
REQ-017 IDLE with accepted op: the unit SHALL latch all inputs and go to BUS if the op is a load or store and the address is aligned; otherwise it SHALL go to DONE.
REQ-018 Aligned means addr[size-1:0]==0 (sizes B/H/W/D need 0/1/2/3 low zero bits); size D with XLEN=32 counts as misaligned.
REQ-019 Misaligned load or store: no bus request; in DONE, out_misalign=1, out_regwrite=0, out_regdata=0.
REQ-020 BUS: dreq_valid=1 and all dreq_* fields SHALL be stable until dresp_ok is sampled high; then capture dresp_data and go to DONE.
REQ-021 dreq_addr SHALL be the latched address with the low log2(XLEN/8) bits cleared; dreq_size = latched size.
REQ-022 Store: dreq_data = wdata replicated across lanes (lane offset = addr low bits); dreq_strobe has (1<<size) ones starting at byte addr low bits.
REQ-023 Load: extract the addressed bytes from dresp_data, then zero- or sign-extend to XLEN per the latched in_unsigned.
REQ-024 DONE: out_valid=1 with a stable bundle until out_ready; on handshake go to IDLE (no same-cycle accept; in_ready is asserted the next cycle).
REQ-025 out_regdata: the extended load data for a load; the latched result for a pass-through op or a store; out_regwrite = latched regwrite except 0 on misalign.
REQ-026 Latency: a pass-through or misaligned op SHALL show out_valid one cycle after acceptance; a memory op SHALL show out_valid one cycle after the dresp_ok cycle.
REQ-027 dresp_ok outside BUS SHALL be ignored.
REQ-028 out_valid and dreq_valid SHALL never be high together.

Reset
REQ-029 On reset assertion the unit SHALL go to IDLE immediately with out_valid=0, dreq_valid=0, and all latched registers and outputs 0, including mid-BUS (an outstanding request is abandoned).
REQ-030 After reset deasserts, in_ready SHALL be 1 in the first cycle.

Verification
REQ-031 Pass-through, result=0x1234, dst=5, regwrite=1, out_ready=1 -> out_valid one cycle later with regdata=0x1234, dst=5; in_ready high again the cycle after.
REQ-032 XLEN=64, load H signed at addr 0x1006, bus returns 0x8001_0000_0000_0000 after 3 wait cycles -> dreq_addr=0x1000, strobe=0; out_regdata=0xFFFF_FFFF_FFFF_8001 one cycle after ok.
REQ-033 Store B at addr 0x2003, wdata=0xAB -> dreq_strobe=0x08, byte 3 of dreq_data=0xAB; fields held constant across 5 stall cycles until ok.
REQ-034 Load W at addr 0x3002 -> no dreq_valid; out_misalign=1, regwrite=0 one cycle after acceptance.
REQ-035 Reset asserted while in BUS -> dreq_valid=0 asynchronously, out_valid=0; after release in_ready=1 and a new load completes normally.
REQ-036 out_ready held low 4 cycles in DONE -> out bundle stable, in_ready=0 throughout, a dresp_ok pulse is ignored.
